// File: rtl/sort_pkg.sv
// Shared definitions for the parallel sorter and its stream-side controller.
package sort_pkg;

  localparam int SORT_N       = 6;
  localparam int SORT_WIDTH   = 8;
  localparam int SORT_TIMEOUT = 32;

  typedef enum logic [2:0] {
    LOAD,
    LAUNCH,
    WAIT,
    CAPTURE,
    DRAIN
  } state_t;

endpackage

// File: rtl/sort_order_checker.sv
// Watches words leaving the controller and flags any word smaller than its predecessor.
module sort_order_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             check,
  input  logic             first,
  input  logic [WIDTH-1:0] data,
  output logic             err
);

  logic [WIDTH-1:0] prev;

  // The first word of a frame only seeds prev; equal words are accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      err  <= 1'b0;
    end else begin
      if (clear) begin
        err <= 1'b0;
      end else if (check && !first && (data < prev)) begin
        err <= 1'b1;
      end
      if (check) begin
        prev <= data;
      end
    end
  end

endmodule

// File: rtl/sort_stream_ctrl.sv
// Host-side controller for the parallel sorter: gathers a frame from a stream, launches
// the sort, waits for done, and replays the sorted words with an ascending-order check.
module sort_stream_ctrl
  import sort_pkg::*;
#(
  parameter int N       = SORT_N,
  parameter int WIDTH   = SORT_WIDTH,
  parameter int TIMEOUT = SORT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  output logic               sort_start,
  output logic [N*WIDTH-1:0] sort_data,
  input  logic               sort_done,
  input  logic [N*WIDTH-1:0] sort_result,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_last,
  output logic               busy,
  output logic               err_order,
  output logic               err_timeout
);

  localparam int CW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt, idx;
  logic [TW-1:0]    tmo;
  logic [WIDTH-1:0] frame     [N];
  logic [WIDTH-1:0] out_words [N];
  logic             accept, drain_hs, first_accept, timeout_hit;

  // Handshakes are decoded from the state rather than from s_ready/m_valid to keep
  // the output decode free of combinational feedback.
  assign accept       = s_valid && (state_q == LOAD);
  assign drain_hs     = m_ready && (state_q == DRAIN);
  assign first_accept = accept && (cnt == '0);
  assign timeout_hit  = (state_q == WAIT) && !sort_done && (tmo == TMO_LAST);

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign sort_data[g*WIDTH +: WIDTH] = frame[g];
  end

  assign m_data = out_words[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    sort_start = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    busy       = 1'b1;
    case (state_q)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid && (cnt == LAST_IDX)) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        sort_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (sort_done) begin
          state_d = CAPTURE;
        end else if (tmo == TMO_LAST) begin
          state_d = LOAD;
        end
      end
      CAPTURE: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_last  = (idx == LAST_IDX);
        if (m_ready && (idx == LAST_IDX)) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // The frame is only written in LOAD, so sort_data stays put for the whole sort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      tmo         <= '0;
      err_timeout <= 1'b0;
      for (int i = 0; i < N; i++) begin
        frame[i]     <= '0;
        out_words[i] <= '0;
      end
    end else begin
      if (accept) begin
        frame[cnt] <= s_data;
        cnt        <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      end

      if (state_q == LAUNCH) begin
        tmo <= '0;
      end else if (state_q == WAIT) begin
        tmo <= tmo + 1'b1;
      end

      if (first_accept) begin
        err_timeout <= 1'b0;
      end else if (timeout_hit) begin
        err_timeout <= 1'b1;
      end

      if (state_q == CAPTURE) begin
        for (int i = 0; i < N; i++) begin
          out_words[i] <= sort_result[i*WIDTH +: WIDTH];
        end
        idx <= '0;
      end else if (drain_hs) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  sort_order_checker #(
    .WIDTH(WIDTH)
  ) u_order_checker (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(first_accept),
    .check(drain_hs),
    .first(idx == '0),
    .data (m_data),
    .err  (err_order)
  );

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Directed bench for sort_stream_ctrl with a behavioural sorter that answers 8 cycles after start.
module tb_sort_stream_ctrl;

  localparam int N = 6;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic           sort_start;
  logic [N*W-1:0] sort_data;
  logic           sort_done;
  logic [N*W-1:0] sort_result;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic           busy;
  logic           err_order;
  logic           err_timeout;

  int errors = 0;
  int checks = 0;

  // 0: correct sorter, 1: never answers, 2: returns a fixed mis-ordered frame
  int sorter_mode = 0;
  int start_count;
  int countdown;
  logic [W-1:0] latched [N];
  logic [W-1:0] swap_tmp;

  sort_stream_ctrl #(
    .N      (N),
    .WIDTH  (W),
    .TIMEOUT(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .sort_start (sort_start),
    .sort_data  (sort_data),
    .sort_done  (sort_done),
    .sort_result(sort_result),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .err_order  (err_order),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack6(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d,
                                           input logic [W-1:0] e, input logic [W-1:0] f);
    return {f, e, d, c, b, a};
  endfunction

  // Behavioural sorter: reacts just after each rising edge, done is a one-cycle pulse.
  initial begin
    sort_done   = 1'b0;
    sort_result = '0;
    start_count = 0;
    countdown   = 0;
    forever begin
      @(posedge clk);
      #1;
      sort_done = 1'b0;
      if (sort_start) begin
        start_count++;
        for (int i = 0; i < N; i++) latched[i] = sort_data[i*W +: W];
        countdown = 8;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0 && sorter_mode != 1) begin
          if (sorter_mode == 2) begin
            sort_result = pack6(8'd1, 8'd2, 8'd7, 8'd5, 8'd8, 8'd9);
          end else begin
            for (int i = 0; i < N - 1; i++) begin
              for (int j = 0; j < N - 1 - i; j++) begin
                if (latched[j] > latched[j+1]) begin
                  swap_tmp     = latched[j];
                  latched[j]   = latched[j+1];
                  latched[j+1] = swap_tmp;
                end
              end
            end
            for (int i = 0; i < N; i++) sort_result[i*W +: W] = latched[i];
          end
          sort_done = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one input word and returns on the falling edge after it was accepted.
  task automatic applyStimulus(input logic [W-1:0] word);
    int waited = 0;
    s_valid = 1'b1;
    s_data  = word;
    while (!s_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("s_ready_wait", 64'(s_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [N*W-1:0] f);
    for (int i = 0; i < N; i++) applyStimulus(f[i*W +: W]);
    s_valid = 1'b0;
  endtask

  // Collects stop_at words; stall applies the ready pattern 1,0,0 per valid cycle.
  // err_order is expected once the word at err_at has been handshaken.
  task automatic drainFrame(input string tag, input logic [N*W-1:0] exp, input bit stall,
                            input int err_at, input int stop_at);
    int   got  = 0;
    int   cyc  = 0;
    int   vcyc = 0;
    logic rdy;
    while (got < stop_at && cyc < 300) begin
      rdy     = stall ? (vcyc % 3 == 0) : 1'b1;
      m_ready = rdy;
      if (m_valid) begin
        checkOutput({tag, "_data"}, 64'(m_data), 64'(exp[got*W +: W]));
        checkOutput({tag, "_last"}, 64'(m_last), 64'(got == N - 1));
        checkOutput({tag, "_err_order"}, 64'(err_order), 64'(got > err_at));
        if (rdy) got++;
        vcyc++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    checkOutput({tag, "_word_count"}, 64'(got), 64'(stop_at));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N*W-1:0] f1, sorted1, fdup, sorted_dup, faulty;
    int waited;
    bit seen_valid;

    f1         = pack6(8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2);
    sorted1    = pack6(8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd9);
    fdup       = pack6(8'd4, 8'd4, 8'd0, 8'd255, 8'd4, 8'd0);
    sorted_dup = pack6(8'd0, 8'd0, 8'd4, 8'd4, 8'd4, 8'd255);
    faulty     = pack6(8'd1, 8'd2, 8'd7, 8'd5, 8'd8, 8'd9);

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_sort_start", 64'(sort_start), 64'd0);
    checkOutput("rst_sort_data", 64'(sort_data), 64'd0);
    checkOutput("rst_err_order", 64'(err_order), 64'd0);
    checkOutput("rst_err_timeout", 64'(err_timeout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_s_ready", 64'(s_ready), 64'd1);

    $display("[TB] basic frame");
    sendFrame(f1);
    checkOutput("launch_start", 64'(sort_start), 64'd1);
    checkOutput("launch_data", 64'(sort_data), 64'(f1));
    checkOutput("launch_s_ready", 64'(s_ready), 64'd0);
    waited = 0;
    while (!sort_done && waited < 60) begin
      @(negedge clk);
      checkOutput("wait_start_low", 64'(sort_start), 64'd0);
      waited++;
    end
    checkOutput("done_seen", 64'(sort_done), 64'd1);
    checkOutput("wait_data_stable", 64'(sort_data), 64'(f1));
    @(negedge clk);
    checkOutput("capture_m_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    checkOutput("drain_m_valid", 64'(m_valid), 64'd1);
    drainFrame("basic", sorted1, 1'b0, N, N);
    checkOutput("basic_err_order", 64'(err_order), 64'd0);
    checkOutput("basic_start_pulses", 64'(start_count), 64'd1);
    checkOutput("basic_idle_busy", 64'(busy), 64'd0);
    checkOutput("basic_idle_s_ready", 64'(s_ready), 64'd1);

    $display("[TB] stalled drain");
    sendFrame(f1);
    drainFrame("stall", sorted1, 1'b1, N, N);
    checkOutput("stall_start_pulses", 64'(start_count), 64'd2);
    checkOutput("stall_err_order", 64'(err_order), 64'd0);

    $display("[TB] duplicate words");
    sendFrame(fdup);
    drainFrame("dup", sorted_dup, 1'b0, N, N);
    checkOutput("dup_err_order", 64'(err_order), 64'd0);

    $display("[TB] sorter timeout");
    sorter_mode = 1;
    sendFrame(f1);
    seen_valid = 1'b0;
    repeat (32) begin
      @(negedge clk);
      if (m_valid) seen_valid = 1'b1;
    end
    checkOutput("tmo_last_wait_busy", 64'(busy), 64'd1);
    checkOutput("tmo_last_wait_err", 64'(err_timeout), 64'd0);
    @(negedge clk);
    checkOutput("tmo_err_timeout", 64'(err_timeout), 64'd1);
    checkOutput("tmo_s_ready", 64'(s_ready), 64'd1);
    checkOutput("tmo_busy", 64'(busy), 64'd0);
    checkOutput("tmo_no_m_valid", 64'(seen_valid | m_valid), 64'd0);
    sorter_mode = 0;
    applyStimulus(fdup[0 +: W]);
    checkOutput("tmo_cleared", 64'(err_timeout), 64'd0);
    for (int i = 1; i < N; i++) applyStimulus(fdup[i*W +: W]);
    s_valid = 1'b0;
    drainFrame("after_tmo", sorted_dup, 1'b0, N, N);
    checkOutput("after_tmo_starts", 64'(start_count), 64'd5);

    $display("[TB] faulty sorter");
    sorter_mode = 2;
    sendFrame(f1);
    drainFrame("faulty", faulty, 1'b0, 3, N);
    checkOutput("faulty_err_order", 64'(err_order), 64'd1);
    sorter_mode = 0;

    $display("[TB] reset during drain");
    sendFrame(f1);
    drainFrame("pre_rst", sorted1, 1'b0, N, 3);
    checkOutput("pre_rst_word3", 64'(m_data), 64'(sorted1[3*W +: W]));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendFrame(fdup);
    checkOutput("post_rst_launch", 64'(sort_data), 64'(fdup));
    drainFrame("post_rst", sorted_dup, 1'b0, N, N);
    checkOutput("post_rst_err_order", 64'(err_order), 64'd0);
    checkOutput("post_rst_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
